// File: rtl/logic_op_sched.sv
// logic_op_sched: round-robin arbiter sharing one logical-op evaluator between two requesters
module logic_op_sched #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_result,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t state, state_n;
  logic ptr, g1, hs, id_q, an, bn, res;
  logic [W-1:0] a_q, b_q;
  logic [1:0] op_q;
  assign g1 = req1_valid && (!req0_valid || ptr);
  assign req0_ready = rst_n && state == IDLE && req0_valid && !g1;
  assign req1_ready = rst_n && state == IDLE && g1;
  assign hs = req0_ready || req1_ready;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign an = |a_q;
  assign bn = |b_q;
  assign res = op_q[1] ? (op_q[0] ? !bn : !an) : (op_q[0] ? an || bn : an && bn);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (hs ? EVAL : IDLE) :
              state == EVAL ? RESP :
              (rsp_ready ? IDLE : RESP);
  always_ff @(posedge clk)
    if (hs) begin
      a_q  <= g1 ? req1_a : req0_a;
      b_q  <= g1 ? req1_b : req0_b;
      op_q <= g1 ? req1_op : req0_op;
      id_q <= g1;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr        <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 1'b0;
    end else begin
      if (hs) ptr <= !g1;
      if (state == EVAL) begin
        rsp_id     <= id_q;
        rsp_result <= res;
      end
    end
endmodule
